game_ctrl: RTL and testbench

Top-level game sequencer for Flappy Bird. Sits beside the renderer in `game`. It owns the `reset_score`/`reset_physics` controls of `obstacle_generator` and the bird physics, and gates their advance with `run`. It detects bird/pipe and bird/boundary collisions from per-pixel flags during the VGA scan, and keeps a high score.

---
 rtl/game_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/HIT/OVER flow, collision latch, high score.
// Optional high-score tracking is enabled by defining GAME_CTRL_HIGH_SCORE_EN.
module game_ctrl #(
  parameter int HIT_FRAMES = 30,
  parameter int CEIL_Y     = 30,
  parameter int FLOOR_Y    = 479
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pressed,
  input  logic       frame_start,
  input  logic       bird_px,
  input  logic       pipe_px,
  input  logic [9:0] bird_y,
  input  logic [6:0] score,
  output logic       reset_score,
  output logic       reset_physics,
  output logic       run,
  output logic       game_over,
  output logic [1:0] state,
  output logic [6:0] high_score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [9:0] CEIL_C     = 10'(CEIL_Y);
  localparam logic [9:0] FLOOR_C    = 10'(FLOOR_Y);
  localparam logic [5:0] HIT_LAST_C = 6'(HIT_FRAMES - 1);

  state_t     state_r;
  state_t     state_nx_s;
  logic       btn_q_r;
  logic       btn_rise_s;
  logic       hit_now_s;
  logic       hit_l_r;
  logic       hit_l_nx_s;
  logic [5:0] hit_cnt_r;
  logic [5:0] hit_cnt_nx_s;
  logic       reset_score_r;
  logic       reset_physics_r;
  logic       run_r;
  logic       game_over_r;

  assign btn_rise_s = btn_pressed & ~btn_q_r;
  assign hit_now_s  = (bird_px & pipe_px) | (bird_y <= CEIL_C) | (bird_y >= FLOOR_C);

  // Next-state, collision latch and hit-frame counter decode.
  always_comb begin
    state_nx_s   = state_r;
    hit_l_nx_s   = hit_l_r;
    hit_cnt_nx_s = hit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        hit_l_nx_s   = 1'b0;
        hit_cnt_nx_s = 6'd0;
        if (btn_rise_s) begin
          state_nx_s = ST_PLAY;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (frame_start) begin
          // A hit on the frame_start cycle still belongs to the frame that is ending.
          hit_l_nx_s = 1'b0;
          if (hit_l_r || hit_now_s) begin
            state_nx_s   = ST_HIT;
            hit_cnt_nx_s = 6'd0;
          end else begin
            state_nx_s = ST_PLAY;
          end
        end else if (hit_now_s) begin
          hit_l_nx_s = 1'b1;
        end else begin
          hit_l_nx_s = hit_l_r;
        end
      end
      ST_HIT: begin
        hit_l_nx_s = 1'b0;
        if (frame_start) begin
          hit_cnt_nx_s = hit_cnt_r + 6'd1;
          if (hit_cnt_r == HIT_LAST_C) begin
            state_nx_s = ST_OVER;
          end else begin
            state_nx_s = ST_HIT;
          end
        end else begin
          state_nx_s = ST_HIT;
        end
      end
      ST_OVER: begin
        hit_l_nx_s = 1'b0;
        if (btn_rise_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OVER;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        hit_l_nx_s   = 1'b0;
        hit_cnt_nx_s = 6'd0;
      end
    endcase
  end

  // State, control registers and outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      btn_q_r         <= 1'b0;
      hit_l_r         <= 1'b0;
      hit_cnt_r       <= 6'd0;
      reset_score_r   <= 1'b1;
      reset_physics_r <= 1'b1;
      run_r           <= 1'b0;
      game_over_r     <= 1'b0;
    end else begin
      state_r         <= state_nx_s;
      btn_q_r         <= btn_pressed;
      hit_l_r         <= hit_l_nx_s;
      hit_cnt_r       <= hit_cnt_nx_s;
      reset_score_r   <= (state_nx_s == ST_IDLE);
      reset_physics_r <= (state_nx_s == ST_IDLE);
      run_r           <= (state_nx_s == ST_PLAY);
      game_over_r     <= (state_nx_s == ST_OVER);
    end
  end

  assign state         = state_r;
  assign reset_score   = reset_score_r;
  assign reset_physics = reset_physics_r;
  assign run           = run_r;
  assign game_over     = game_over_r;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [6:0] high_score_r;
  logic [6:0] high_score_nx_s;

  // Capture the final score once, on the cycle that enters OVER.
  always_comb begin
    high_score_nx_s = high_score_r;
    if ((state_nx_s == ST_OVER) && (state_r != ST_OVER) && (score > high_score_r)) begin
      high_score_nx_s = score;
    end else begin
      high_score_nx_s = high_score_r;
    end
  end

  // High-score register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_score_r <= 7'd0;
    end else begin
      high_score_r <= high_score_nx_s;
    end
  end

  assign high_score = high_score_r;
`else
  logic unused_score_s;
  assign unused_score_s = ^score;
  assign high_score     = 7'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with HIT_FRAMES=3.
module tb_game_ctrl;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_pressed;
  logic       frame_start;
  logic       bird_px;
  logic       pipe_px;
  logic [9:0] bird_y;
  logic [6:0] score;
  logic       reset_score;
  logic       reset_physics;
  logic       run;
  logic       game_over;
  logic [1:0] state;
  logic [6:0] high_score;

  int checks;
  int failures;

  game_ctrl #(.HIT_FRAMES(3), .CEIL_Y(30), .FLOOR_Y(479)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_pressed  (btn_pressed),
    .frame_start  (frame_start),
    .bird_px      (bird_px),
    .pipe_px      (pipe_px),
    .bird_y       (bird_y),
    .score        (score),
    .reset_score  (reset_score),
    .reset_physics(reset_physics),
    .run          (run),
    .game_over    (game_over),
    .state        (state),
    .high_score   (high_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic press();
    btn_pressed = 1'b1;
    step();
    btn_pressed = 1'b0;
    step();
  endtask

  // Walk HIT through 3 frame_starts and check OVER plus the recorded high score.
  task automatic hit_to_over(input string tag, input logic [6:0] exp_hs);
    frame();
    check_val({tag, "_hit_f1"}, 32'(state), 32'd2);
    press();
    check_val({tag, "_hit_btn_ignored"}, 32'(state), 32'd2);
    frame();
    check_val({tag, "_hit_f2"}, 32'(state), 32'd2);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val({tag, "_over_state"}, 32'(state), 32'd3);
    check_val({tag, "_over_game_over"}, 32'(game_over), 32'd1);
    check_val({tag, "_over_run"}, 32'(run), 32'd0);
    check_val({tag, "_over_reset"}, 32'(reset_score), 32'd0);
    check_val({tag, "_high_score"}, 32'(high_score), HS_EN ? 32'(exp_hs) : 32'd0);
    step();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    btn_pressed = 1'b0;
    frame_start = 1'b0;
    bird_px     = 1'b0;
    pipe_px     = 1'b0;
    bird_y      = 10'd200;
    score       = 7'd0;
    #12;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_reset_score", 32'(reset_score), 32'd1);
    check_val("rst_reset_physics", 32'(reset_physics), 32'd1);
    check_val("rst_run", 32'(run), 32'd0);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    check_val("rst_high_score", 32'(high_score), 32'd0);
    #1 rst_n = 1'b1;
    step();
    check_val("idle_hold", 32'(state), 32'd0);

    // Game 1: pipe overlap mid-frame, final score 5.
    btn_pressed = 1'b1;
    step();
    check_val("g1_play_state", 32'(state), 32'd1);
    check_val("g1_play_run", 32'(run), 32'd1);
    check_val("g1_play_reset", 32'(reset_physics), 32'd0);
    btn_pressed = 1'b0;
    step();
    frame();
    check_val("g1_no_hit_frame", 32'(state), 32'd1);
    bird_px = 1'b1;
    pipe_px = 1'b1;
    step();
    bird_px = 1'b0;
    pipe_px = 1'b0;
    step();
    step();
    check_val("g1_latched_wait", 32'(state), 32'd1);
    score = 7'd5;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val("g1_hit_state", 32'(state), 32'd2);
    check_val("g1_hit_run", 32'(run), 32'd0);
    step();
    hit_to_over("g1", 7'd5);

    // Button held through OVER -> IDLE must not restart play.
    btn_pressed = 1'b1;
    step();
    check_val("held_idle_state", 32'(state), 32'd0);
    check_val("held_idle_reset", 32'(reset_score), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check_val("held_stays_idle", 32'(state), 32'd0);
    btn_pressed = 1'b0;
    step();
    check_val("release_idle", 32'(state), 32'd0);

    // Game 2: boundary checks, final score 12.
    press();
    check_val("g2_play", 32'(state), 32'd1);
    bird_y = 10'd31;
    step();
    bird_y = 10'd478;
    step();
    bird_y = 10'd200;
    frame();
    check_val("g2_y31_478_no_hit", 32'(state), 32'd1);
    bird_y = 10'd30;
    step();
    bird_y = 10'd200;
    step();
    check_val("g2_ceil_wait", 32'(state), 32'd1);
    score = 7'd12;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val("g2_ceil_hit", 32'(state), 32'd2);
    step();
    hit_to_over("g2", 7'd12);

    // Game 3: floor hit coincident with frame_start, final score 7.
    press();
    press();
    check_val("g3_play", 32'(state), 32'd1);
    frame_start = 1'b1;
    bird_y      = 10'd479;
    step();
    frame_start = 1'b0;
    bird_y      = 10'd200;
    check_val("g3_floor_same_cycle", 32'(state), 32'd2);
    score = 7'd7;
    step();
    hit_to_over("g3", 7'd12);

    // Game 4: hit right after frame_start belongs to the new frame; then reset in HIT.
    press();
    press();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    bird_y      = 10'd479;
    step();
    bird_y = 10'd200;
    check_val("g4_after_fs_wait", 32'(state), 32'd1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val("g4_hit", 32'(state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_state", 32'(state), 32'd0);
    check_val("async_rst_reset", 32'(reset_physics), 32'd1);
    check_val("async_rst_run", 32'(run), 32'd0);
    check_val("async_rst_high_score", 32'(high_score), 32'd0);
    #3 rst_n = 1'b1;
    step();
    step();
    check_val("post_rst_idle", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
